// File: rtl/sar_adc_pkg.sv
// Shared types and analog defaults for the SAR ADC. The rail and gain values
// match the operational_amplifier defaults so the ADC covers its full output swing.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam real DEF_V_LO     = -4.5;
    localparam real DEF_V_HI     = 4.5;
    localparam real DEF_CMP_GAIN = 100000.0;
    localparam real DEF_CMP_SAT  = 4.5;

    // Linear gain inside the clip window, hard clip to +/-sat outside it.
    function automatic real clip_gain(input real d, input real gain, input real sat);
        real r;
        if (d > sat / gain) begin
            r = sat;
        end else if (d < -sat / gain) begin
            r = -sat;
        end else begin
            r = gain * d;
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_comparator.sv
// Real-valued comparator: open-loop gain on (in_plus - in_minus), clipped to
// the same saturation rails as the operational_amplifier model.
module sar_comparator
    import sar_adc_pkg::*;
#(
    parameter real GAIN = DEF_CMP_GAIN,
    parameter real SAT  = DEF_CMP_SAT
) (
    input  real in_plus,
    input  real in_minus,
    output real out
);

    always_comb begin
        out = clip_gain(in_plus - in_minus, GAIN, SAT);
    end

endmodule

// File: rtl/sar_adc_converter.sv
// Successive-approximation ADC: samples a real input, binary-searches it against
// an internal real DAC one bit per clock, and presents the code with a done pulse.
module sar_adc_converter
    import sar_adc_pkg::*;
#(
    parameter int  N_BITS   = 8,
    parameter real V_LO     = DEF_V_LO,
    parameter real V_HI     = DEF_V_HI,
    parameter real CMP_GAIN = DEF_CMP_GAIN,
    parameter real CMP_SAT  = DEF_CMP_SAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  real               vin,
    output logic              ready,
    output logic              done,
    output logic [N_BITS-1:0] code,
    output real               dac_v,
    output real               cmp_out
);

    localparam int                IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam real               LSB       = (V_HI - V_LO) / (2.0 ** N_BITS);
    localparam logic [N_BITS-1:0] TRIAL_MSB = N_BITS'(1) << (N_BITS - 1);

    state_e             state_q, state_d;
    logic [N_BITS-1:0]  trial_q, trial_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_BITS-1:0]  code_q, code_d;
    real                held_q, held_d;
    logic               keep;

    always_comb begin
        dac_v = V_LO + LSB * real'(trial_q);
    end

    sar_comparator #(
        .GAIN (CMP_GAIN),
        .SAT  (CMP_SAT)
    ) u_cmp (
        .in_plus  (held_q),
        .in_minus (dac_v),
        .out      (cmp_out)
    );

    // Exact ties leave cmp_out at 0.0, so a level equal to the input is rejected.
    assign keep = (cmp_out > 0.0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            trial_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            held_q  <= V_LO;
        end else begin
            state_q <= state_d;
            trial_q <= trial_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trial_d = trial_q;
        idx_d   = idx_q;
        code_d  = code_q;
        held_d  = held_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    held_d  = vin;
                    trial_d = TRIAL_MSB;
                    idx_d   = IDX_W'(N_BITS - 1);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (!keep) begin
                    trial_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    trial_d[idx_q - 1'b1] = 1'b1;
                    idx_d                 = idx_q - 1'b1;
                end else begin
                    // Publish only once the LSB is resolved.
                    code_d  = trial_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
        code  = code_q;
    end

endmodule

// File: tb/tb_sar_adc_converter.sv
// Directed and randomized bench for sar_adc_converter against an arithmetic
// model: code = largest k with V_LO + k*LSB < vin.
module tb_sar_adc_converter;

    localparam int  N      = 8;
    localparam real TB_LO  = -4.5;
    localparam real TB_HI  = 4.5;
    localparam real TB_LSB = (TB_HI - TB_LO) / 256.0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    real          vin;
    logic         ready;
    logic         done;
    logic [N-1:0] code;
    real          dac_v;
    real          cmp_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sar_adc_converter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vin     (vin),
        .ready   (ready),
        .done    (done),
        .code    (code),
        .dac_v   (dac_v),
        .cmp_out (cmp_out)
    );

    always #5 clk = ~clk;

    function automatic int model(input real v);
        int e;
        e = 0;
        for (int k = 0; k < (1 << N); k++) begin
            if (TB_LO + real'(k) * TB_LSB < v) e = k;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_conv(input real v, input string tag);
        int n;
        chk({tag, "_ready_before"}, 32'(ready), 1);
        vin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(ready), 0);
        wait_done(n);
        chk({tag, "_latency"}, n, N);
        chk({tag, "_code"}, 32'(code), model(v));
        tick();
        chk({tag, "_done_width"}, 32'(done), 0);
        chk({tag, "_ready_after"}, 32'(ready), 1);
    endtask

    initial begin
        int  n;
        int  d1;
        int  d2;
        real rv;

        rst   = 1'b1;
        start = 1'b0;
        vin   = 0.0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_code", 32'(code), 0);
        chk_r("rst_dac", dac_v, TB_LO);
        chk_r("rst_cmp", cmp_out, 0.0);
        rst = 1'b0;
        tick();

        // First conversion: DAC starts at mid-scale trial.
        vin   = 1.0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_r("first_trial_dac", dac_v, 0.0);
        chk_r("first_cmp_clip", cmp_out, 4.5);
        wait_done(n);
        chk("v1_latency", n, N);
        chk("v1_code", 32'(code), 156);
        tick();
        chk("v1_done_width", 32'(done), 0);
        chk("v1_ready_after", 32'(ready), 1);

        run_conv(0.0, "v0");
        chk("v0_tie_code", 32'(code), 127);
        run_conv(0.01, "v001");
        chk("v001_code", 32'(code), 128);
        run_conv(4.5, "vhi");
        chk("vhi_code", 32'(code), 255);
        run_conv(6.0, "vover");
        chk("vover_code", 32'(code), 255);
        run_conv(-4.5, "vlo");
        chk("vlo_code", 32'(code), 0);
        run_conv(-6.0, "vunder");
        chk("vunder_code", 32'(code), 0);

        // Input changes after acceptance and a held start must not disturb the conversion.
        vin   = 1.0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= N; k++) begin
            tick();
            if (k == 3) vin = -3.0;
            if (k < N) chk("held_busy", 32'(ready), 0);
        end
        chk("held_done", 32'(done), 1);
        chk("held_code", 32'(code), 156);
        start = 1'b0;
        tick();
        chk("held_ready", 32'(ready), 1);
        tick();
        chk("held_no_queue", 32'(ready), 1);
        chk("held_code_kept", 32'(code), 156);

        // Reset in the middle of a conversion.
        vin   = 2.0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_code", 32'(code), 0);
        rst = 1'b0;
        run_conv(-1.0, "after_rst");
        chk("after_rst_code", 32'(code), 99);

        // Back-to-back conversions with start on the first ready cycle.
        vin   = 2.0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        d1 = cyc;
        chk("b2b_a_code", 32'(code), 184);
        tick();
        chk("b2b_a_width", 32'(done), 0);
        chk("b2b_a_ready", 32'(ready), 1);
        vin   = -2.0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        d2 = cyc;
        chk("b2b_spacing", d2 - d1, 10);
        chk("b2b_b_code", 32'(code), 71);
        tick();
        chk("b2b_b_width", 32'(done), 0);

        for (int i = 0; i < 24; i++) begin
            rv = -6.0 + real'($urandom_range(0, 120000)) / 10000.0;
            run_conv(rv, "rand");
        end
        for (int i = 0; i < 6; i++) begin
            rv = TB_LO + real'($urandom_range(0, 255)) * TB_LSB;
            run_conv(rv, "rand_level");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
